// File: rtl/uart_rx_to_axi_stream.sv
// UART frame receiver: NUM_WORDS LSB-first packets per frame, delivered as one
// AXI-Stream beat through a single-entry output register.
module uart_rx_to_axi_stream #(
  parameter int CLOCKS_PER_PULSE = 4,
  parameter int W_OUT            = 16,
  parameter int BITS_PER_WORD    = 8,
  parameter int PACKET_SIZE      = BITS_PER_WORD + 5
) (
  input  logic                                              clk,
  input  logic                                              rstn,
  input  logic                                              rx,
  output logic [W_OUT/BITS_PER_WORD-1:0][BITS_PER_WORD-1:0] m_data,
  output logic                                              m_valid,
  input  logic                                              m_ready,
  output logic                                              framing_err,
  output logic                                              overflow
);

  localparam int NUM_WORDS = W_OUT / BITS_PER_WORD;
  localparam int END_BITS  = PACKET_SIZE - BITS_PER_WORD - 1;
  localparam int CW        = $clog2(CLOCKS_PER_PULSE);
  localparam int BW        = $clog2(BITS_PER_WORD + 1);
  localparam int WW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int BI        = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;

  localparam logic [CW-1:0] HALF_M1   = CW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1   = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(BITS_PER_WORD - 1);
  localparam logic [WW-1:0] LAST_WORD = WW'(NUM_WORDS - 1);

  if (CLOCKS_PER_PULSE < 4 || (CLOCKS_PER_PULSE % 2) != 0) begin : g_bad_cpp
    $error("CLOCKS_PER_PULSE must be even and >= 4");
  end
  if ((W_OUT % BITS_PER_WORD) != 0) begin : g_bad_wout
    $error("W_OUT must be a multiple of BITS_PER_WORD");
  end
  if (END_BITS < 1) begin : g_bad_end
    $error("PACKET_SIZE must leave at least one stop bit");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t                                     state;
  logic                                       rx_meta, rx_s;
  logic [CW-1:0]                              clk_cnt;
  logic [BW-1:0]                              bit_cnt;
  logic [WW-1:0]                              word_cnt;
  logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0]    asm_buf;

  // Synchroniser resets to the idle line level so no false start follows reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      asm_buf     <= '0;
      m_data      <= '0;
      m_valid     <= 1'b0;
      framing_err <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      framing_err <= 1'b0;
      overflow    <= 1'b0;
      if (m_valid && m_ready) m_valid <= 1'b0;

      case (state)
        IDLE: begin
          clk_cnt <= '0;
          if (!rx_s) state <= START;
        end
        // Mid-start-bit recheck rejects short glitches silently.
        START: begin
          if (clk_cnt == HALF_M1) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        DATA: begin
          if (clk_cnt == FULL_M1) begin
            clk_cnt                              <= '0;
            asm_buf[word_cnt][bit_cnt[BI-1:0]]   <= rx_s;
            bit_cnt                              <= bit_cnt + BW'(1);
            if (bit_cnt == LAST_BIT) state <= STOP;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        STOP: begin
          if (clk_cnt == FULL_M1) begin
            clk_cnt <= '0;
            if (!rx_s) begin
              framing_err <= 1'b1;
              word_cnt    <= '0;
              state       <= WAIT_IDLE;
            end else begin
              state <= IDLE;
              if (word_cnt == LAST_WORD) begin
                word_cnt <= '0;
                // A held beat wins; the fresh frame is dropped and flagged.
                if (m_valid && !m_ready) begin
                  overflow <= 1'b1;
                end else begin
                  m_data  <= asm_buf;
                  m_valid <= 1'b1;
                end
              end else begin
                word_cnt <= word_cnt + WW'(1);
              end
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        WAIT_IDLE: if (rx_s) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_to_axi_stream.sv
// Scoreboard bench: stimulus serialises frames and queues the expected beats,
// an independent monitor pops and compares on every accepted beat.
module tb_uart_rx_to_axi_stream;
  localparam int CPP = 4;
  localparam int BPW = 8;
  localparam int W   = 16;
  localparam int NW  = W / BPW;

  logic                    clk = 1'b0;
  logic                    rstn, rx, m_ready, m_valid, framing_err, overflow;
  logic [NW-1:0][BPW-1:0]  m_data;

  int          vectors = 0, miscompares = 0;
  int          n_ferr = 0, n_ovf = 0;
  int          ready_mode = 1;
  logic [15:0] exp_q[$];
  logic        pv = 1'b0, pr = 1'b0;
  logic [15:0] pd = '0;

  uart_rx_to_axi_stream #(
    .CLOCKS_PER_PULSE(CPP), .W_OUT(W), .BITS_PER_WORD(BPW), .PACKET_SIZE(BPW + 5)
  ) dut (
    .clk(clk), .rstn(rstn), .rx(rx), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .framing_err(framing_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Consumer: m_ready changes just after posedge, away from the monitor's sample.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          check("hold_valid", 32'(m_valid), 32'd1);
          check("hold_data", 32'(m_data), 32'(pd));
        end
        if (framing_err) n_ferr++;
        if (overflow) n_ovf++;
        if (framing_err || overflow)
          check("err_exclusive", 32'(framing_err & overflow), 32'd0);
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_beat: got %0h, expected no beat", m_data);
          end else begin
            check("beat", 32'(m_data), 32'(exp_q.pop_front()));
          end
        end
        pv = m_valid;
        pr = m_ready;
        pd = m_data;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPP) @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] d, input bit bad_stop, input int nstop);
    send_bit(1'b0);
    for (int i = 0; i < BPW; i++) send_bit(d[i]);
    send_bit(!bad_stop);
    for (int i = 1; i < nstop; i++) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic [15:0] f, input int nstop, input bit expect_beat);
    if (expect_beat) exp_q.push_back(f);
    for (int w = 0; w < NW; w++) send_word(f[w*BPW +: BPW], 1'b0, nstop);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    logic [15:0] f;
    int          gap;
    rx   = 1'b1;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_ferr", 32'(framing_err), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    // Default frame
    send_frame(16'h3CA5, 4, 1'b1);
    drain("default_drain");
    check("default_ferr", 32'(n_ferr), 32'd0);
    check("default_ovf", 32'(n_ovf), 32'd0);

    // Back-to-back frames as the transmitter would produce them
    send_frame(16'hBEEF, 4, 1'b1);
    send_frame(16'h0000, 4, 1'b1);
    send_frame(16'hFFFF, 4, 1'b1);
    send_frame(16'h8001, 4, 1'b1);
    drain("loop_drain");

    // Backpressure: second frame dropped with a single overflow pulse
    ready_mode = 0;
    repeat (2) @(negedge clk);
    send_frame(16'h1234, 4, 1'b1);
    send_frame(16'h5678, 4, 1'b0);
    repeat (10) @(negedge clk);
    check("bp_ovf", 32'(n_ovf), 32'd1);
    check("bp_valid", 32'(m_valid), 32'd1);
    check("bp_data", 32'(m_data), 32'h1234);
    ready_mode = 1;
    drain("bp_drain");
    check("bp_valid_low", 32'(m_valid), 32'd0);

    // Framing error on a first word, then a clean frame with no word skew
    send_word(8'hA5, 1'b1, 4);
    send_frame(16'h3CA5, 4, 1'b1);
    drain("ferr_drain");
    check("ferr_count", 32'(n_ferr), 32'd1);

    // One-clock glitch in idle
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_valid", 32'(m_valid), 32'd0);
    check("glitch_ferr", 32'(n_ferr), 32'd1);
    send_frame(16'h00FF, 4, 1'b1);
    drain("glitch_drain");

    // Randomised frames, gaps and consumer readiness
    ready_mode = 2;
    for (int i = 0; i < 12; i++) begin
      f   = 16'($urandom);
      gap = $urandom_range(1, 6);
      send_frame(f, gap, 1'b1);
    end
    ready_mode = 1;
    drain("rand_drain");
    check("rand_ovf", 32'(n_ovf), 32'd1);
    check("rand_ferr", 32'(n_ferr), 32'd1);

    // Reset mid-DATA of word 1 with a held beat pending
    ready_mode = 0;
    send_frame(16'hAAAA, 4, 1'b0);
    repeat (4) @(negedge clk);
    check("pre_rst_valid", 32'(m_valid), 32'd1);
    send_word(8'h11, 1'b0, 4);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rstn = 1'b0;
    #1;
    check("mid_rst_valid", 32'(m_valid), 32'd0);
    check("mid_rst_data", 32'(m_data), 32'd0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    rstn = 1'b1;
    ready_mode = 1;
    repeat (5) @(negedge clk);
    send_frame(16'hC0DE, 4, 1'b1);
    drain("rst_drain");
    check("rst_ferr_total", 32'(n_ferr), 32'd1);
    check("rst_ovf_total", 32'(n_ovf), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
